cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 45 ++++
 rtl/cdb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// -----------------------------------------------------------------------------
// cdb_pkg
// Shared defaults for the common-data-bus arbiter: requester count, tag and
// result widths, the reserved "no dependency" tag, and a helper that sizes
// index/pointer fields.
// No ports (package).
// -----------------------------------------------------------------------------
package cdb_pkg;

    localparam int N_REQ_DEF  = 4;   // functional units competing for the bus
    localparam int TAG_W_DEF  = 3;   // reservation-station tag width
    localparam int DATA_W_DEF = 16;  // broadcast result width

    // Tag 0 marks "no dependency"; it is never broadcast.
    localparam int TAG_NONE   = 0;

    // Width of an index into n requesters; at least one bit so a single
    // requester still gets a legal vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker. Searches the eligible vector
// starting at ptr_i, wrapping through N-1 back to 0; the first set bit wins.
//
// Ports
//   elig_i    [N-1:0]      eligible requesters
//   ptr_i     [PTR_W-1:0]  index with highest priority this cycle
//   winner_o  [N-1:0]      one-hot winner, zero when nothing is eligible
//   found_o                a winner exists
// -----------------------------------------------------------------------------
module rr_pick
    import cdb_pkg::*;
#(
    parameter int N     = N_REQ_DEF,
    parameter int PTR_W = idx_w(N)
) (
    input  logic [N-1:0]     elig_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     winner_o,
    output logic             found_o
);

    // Two ascending passes: first the indices at or above ptr, then the ones
    // below it. This is the wrap-around search without any modulo arithmetic.
    always_comb begin
        // NOTE: every output gets a default before the search so no path
        // leaves a value unassigned, which would infer a latch.
        winner_o = '0;
        found_o  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found_o && elig_i[i] && (i >= int'(ptr_i))) begin
                winner_o[i] = 1'b1;
                found_o     = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found_o && elig_i[i]) begin
                winner_o[i] = 1'b1;
                found_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Round-robin arbiter for a Tomasulo-style common data bus. Each cycle at most
// one functional unit wins and its tag/result are broadcast (registered, one
// edge after the request). A unit just granted is locked out for one cycle so
// a request still high while it reacts to the grant is harmless, and a lone
// requester is served at most every second cycle. Requests carrying tag 0 are
// ignored and flagged on tag_err.
//
// Ports
//   CLK                          rising-edge clock
//   CLR                          asynchronous active-low reset
//   req      [N_REQ-1:0]         request per functional unit
//   tag_in   [N_REQ*TAG_W-1:0]   producing-station tag, slice i for req[i]
//   data_in  [N_REQ*DATA_W-1:0]  result value, slice i for req[i]
//   grant    [N_REQ-1:0]         registered one-hot (or zero) acknowledge
//   cdb_valid                    registered broadcast strobe
//   cdb_tag  [TAG_W-1:0]         registered broadcast tag (held when idle)
//   cdb_data [DATA_W-1:0]        registered broadcast data (held when idle)
//   tag_err                      pulse: some request carried tag 0
//   bcast_cnt    [15:0]          (CDB_ARBITER_PERF_CNT_EN) cycles with cdb_valid
//   conflict_cnt [15:0]          (CDB_ARBITER_PERF_CNT_EN) edges with >=2 eligible
//
// Build option: define CDB_ARBITER_PERF_CNT_EN to add the saturating
// performance counters; without it those ports do not exist.
// -----------------------------------------------------------------------------
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                    CLK,
    input  logic                    CLR,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*TAG_W-1:0]  tag_in,
    input  logic [N_REQ*DATA_W-1:0] data_in,
    output logic [N_REQ-1:0]        grant,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [DATA_W-1:0]       cdb_data,
    output logic                    tag_err
`ifdef CDB_ARBITER_PERF_CNT_EN
    ,
    output logic [15:0]             bcast_cnt,
    output logic [15:0]             conflict_cnt
`endif
);

    localparam int PTR_W = idx_w(N_REQ);

    logic [N_REQ-1:0]  grant_q,  grant_d;   // also serves as the lockout state
    logic              valid_q,  valid_d;
    logic [TAG_W-1:0]  tag_q,    tag_d;
    logic [DATA_W-1:0] data_q,   data_d;
    logic              err_q,    err_d;
    logic [PTR_W-1:0]  ptr_q,    ptr_d;

    logic [N_REQ-1:0]  tag_zero;
    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  winner;
    logic              found;
    logic [PTR_W-1:0]  win_idx;
    logic [TAG_W-1:0]  sel_tag;
    logic [DATA_W-1:0] sel_data;

    // Eligibility: requesting, real tag, and not granted last cycle.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            tag_zero[i] = (tag_in[i*TAG_W +: TAG_W] == TAG_W'(TAG_NONE));
        end
        elig = req & ~tag_zero & ~grant_q;
    end

    rr_pick #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .elig_i   (elig),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .found_o  (found)
    );

    // Winner is one-hot, so at most one iteration fires.
    always_comb begin
        sel_tag  = '0;
        sel_data = '0;
        win_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner[i]) begin
                sel_tag  = tag_in[i*TAG_W +: TAG_W];
                sel_data = data_in[i*DATA_W +: DATA_W];
                win_idx  = PTR_W'(i);
            end
        end
    end

    // Next state: broadcast on a win, otherwise hold tag/data/ptr.
    always_comb begin
        grant_d = winner;
        valid_d = found;
        tag_d   = found ? sel_tag  : tag_q;
        data_d  = found ? sel_data : data_q;
        err_d   = |(req & tag_zero);
        ptr_d   = ptr_q;
        if (found) begin
            ptr_d = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            grant_q <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            grant_q <= grant_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant     = grant_q;
    assign cdb_valid = valid_q;
    assign cdb_tag   = tag_q;
    assign cdb_data  = data_q;
    assign tag_err   = err_q;

`ifdef CDB_ARBITER_PERF_CNT_EN
    logic [15:0] bcast_q, conflict_q;
    logic        multi_elig;

    // Two or more bits set: clearing the lowest set bit leaves something.
    assign multi_elig = |(elig & (elig - N_REQ'(1)));

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            bcast_q    <= '0;
            conflict_q <= '0;
        end else begin
            if (valid_q && (bcast_q != 16'hFFFF)) begin
                bcast_q <= bcast_q + 16'd1;
            end
            if (multi_elig && (conflict_q != 16'hFFFF)) begin
                conflict_q <= conflict_q + 16'd1;
            end
        end
    end

    assign bcast_cnt    = bcast_q;
    assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed-vector bench for cdb_arbiter (N_REQ=4, TAG_W=3, DATA_W=16).
// Inputs change 1 time unit after a rising edge; outputs are compared at the
// same point, i.e. they show the registered result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int TW = 3;
    localparam int DW = 16;

    logic            CLK;
    logic            CLR;
    logic [N-1:0]    req;
    logic [N*TW-1:0] tag_in;
    logic [N*DW-1:0] data_in;
    logic [N-1:0]    grant;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [DW-1:0]   cdb_data;
    logic            tag_err;
`ifdef CDB_ARBITER_PERF_CNT_EN
    logic [15:0]     bcast_cnt;
    logic [15:0]     conflict_cnt;
`endif

    logic [TW-1:0] tg [N];
    logic [DW-1:0] dt [N];

    int n_vec;
    int n_err;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            tag_in[i*TW +: TW]  = tg[i];
            data_in[i*DW +: DW] = dt[i];
        end
    end

    cdb_arbiter #(
        .N_REQ  (N),
        .TAG_W  (TW),
        .DATA_W (DW)
    ) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .req       (req),
        .tag_in    (tag_in),
        .data_in   (data_in),
        .grant     (grant),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .tag_err   (tag_err)
`ifdef CDB_ARBITER_PERF_CNT_EN
        ,
        .bcast_cnt    (bcast_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] g, input logic v,
                             input logic [2:0] t, input logic [15:0] d);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".valid"}, 32'(cdb_valid), 32'(v));
        check({tag, ".tag"},   32'(cdb_tag), 32'(t));
        check({tag, ".data"},  32'(cdb_data), 32'(d));
    endtask

    int ord [5] = '{0, 1, 2, 3, 0};

    initial begin
        n_vec = 0;
        n_err = 0;
        CLR   = 1'b0;
        req   = '0;
        for (int i = 0; i < N; i++) begin
            tg[i] = '0;
            dt[i] = '0;
        end

        // Held in reset across edges: everything zero.
        repeat (2) @(posedge CLK);
        #1;
        check_all("in_reset", 4'b0000, 1'b0, 3'd0, 16'h0000);
        check("in_reset.err", 32'(tag_err), 32'd0);

        // Release, idle for 5 cycles.
        CLR = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_all("idle", 4'b0000, 1'b0, 3'd0, 16'h0000);
        end

        // Single one-cycle request from unit 1.
        tg[1] = 3'd5;
        dt[1] = 16'h1234;
        req   = 4'b0010;
        tick();
        check_all("single", 4'b0010, 1'b1, 3'd5, 16'h1234);
        req = 4'b0000;
        tick();
        check_all("single_after", 4'b0000, 1'b0, 3'd5, 16'h1234);

        // Asynchronous reset pulse between edges, restores ptr to 0.
        CLR = 1'b0;
        #2;
        check("rst_pulse.tag", 32'(cdb_tag), 32'd0);
        check("rst_pulse.data", 32'(cdb_data), 32'd0);
        CLR = 1'b1;

        // All four requesting: 0,1,2,3,0.
        for (int i = 0; i < N; i++) begin
            tg[i] = 3'(i + 1);
            dt[i] = 16'hA000 + 16'(i);
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_all("rr_all", 4'(1 << ord[k]), 1'b1, 3'(ord[k] + 1), 16'hA000 + 16'(ord[k]));
        end
        req = 4'b0000;
        tick();
        check("rr_all_end.valid", 32'(cdb_valid), 32'd0);

        // Lone continuous requester 2: granted every second cycle. ptr ends at 3.
        tg[2] = 3'd6;
        dt[2] = 16'h0C0C;
        req   = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("lone.grant", 32'(grant), (k % 2 == 0) ? 32'h4 : 32'h0);
            check("lone.valid", 32'(cdb_valid), (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        req = 4'b0000;
        tick();

        // Tag-0 request ignored and flagged; unit 1 still served. ptr ends at 2.
        tg[0] = 3'd0;
        tg[1] = 3'd2;
        dt[1] = 16'h2222;
        req   = 4'b0011;
        tick();
        check_all("tag0_mix", 4'b0010, 1'b1, 3'd2, 16'h2222);
        check("tag0_mix.err", 32'(tag_err), 32'd1);
        req = 4'b0001;
        tick();
        check_all("tag0_only", 4'b0000, 1'b0, 3'd2, 16'h2222);
        check("tag0_only.err", 32'(tag_err), 32'd1);
        req = 4'b0000;
        tick();
        check("tag0_clear.err", 32'(tag_err), 32'd0);

        // ptr held at 2 through idle cycles: among {0,1,3} unit 3 wins.
        tg[0] = 3'd1;
        tg[3] = 3'd4;
        dt[3] = 16'hA003;
        req   = 4'b1011;
        tick();
        check_all("ptr_hold", 4'b1000, 1'b1, 3'd4, 16'hA003);
        req = 4'b0000;
        tick();

        // Reset mid-broadcast drops everything without a clock edge.
        tg[3] = 3'd7;
        dt[3] = 16'hBEEF;
        req   = 4'b1000;
        tick();
        check("pre_rst.valid", 32'(cdb_valid), 32'd1);
        #1;
        CLR = 1'b0;
        #1;
        check_all("mid_rst", 4'b0000, 1'b0, 3'd0, 16'h0000);
        #1;
        CLR = 1'b1;
        tick();
        check_all("post_rst", 4'b1000, 1'b1, 3'd7, 16'hBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
